// File: rtl/tdm_demux4.sv
// tdm_demux4: receive end of a 4-slot TDM link. Hunts for the frame_sync
// marker, collects slots 0..2 in shadow registers, and on the slot-3 beat
// publishes all four channels at once with a one-cycle frame_valid pulse.
//
// Strobe semantics: enable is a one-way slot strobe with no back-pressure.
// A "beat" is any rising clock edge with enable=1; data_in and frame_sync
// are consumed on that edge and ignored otherwise. The state machine is
// observable through locked (LOCKED vs HUNT) and slot (position in frame).
module tdm_demux4 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             frame_sync,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out_u,
    output logic [WIDTH-1:0] out_v,
    output logic [WIDTH-1:0] out_w,
    output logic [WIDTH-1:0] out_x,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] u_q, v_q, w_q, x_q;
    logic [WIDTH-1:0] u_d, v_d, w_d, x_d;
    logic             fv_q, fv_d;
    logic             err_q, err_d;

    // Next-state, shadow capture and frame publication; everything holds by default.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        u_d      = u_q;
        v_d      = v_q;
        w_d      = w_q;
        x_d      = x_q;
        fv_d     = 1'b0;
        err_d    = 1'b0;

        if (enable) begin
            unique case (state_q)
                HUNT: begin
                    // Non-marker beats are simply skipped while hunting.
                    if (frame_sync) begin
                        shadow_d[0] = data_in;
                        slot_d      = 2'd1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (frame_sync) begin
                            shadow_d[0] = data_in;
                            slot_d      = 2'd1;
                        end else begin
                            // Marker missing where expected: lose lock.
                            err_d       = 1'b1;
                            shadow_d[0] = '0;
                            shadow_d[1] = '0;
                            shadow_d[2] = '0;
                            slot_d      = 2'd0;
                            state_d     = HUNT;
                        end
                    end else if (frame_sync) begin
                        // Early marker: drop partial frame, restart at slot 0.
                        err_d       = 1'b1;
                        shadow_d[0] = data_in;
                        shadow_d[1] = '0;
                        shadow_d[2] = '0;
                        slot_d      = 2'd1;
                    end else if (slot_q == 2'd3) begin
                        // Last slot goes straight to out_x so all four update together.
                        u_d    = shadow_q[0];
                        v_d    = shadow_q[1];
                        w_d    = shadow_q[2];
                        x_d    = data_in;
                        fv_d   = 1'b1;
                        slot_d = 2'd0;
                    end else begin
                        if (slot_q == 2'd1) begin
                            shadow_d[1] = data_in;
                        end else begin
                            shadow_d[2] = data_in;
                        end
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State register with synchronous reset dominating all other inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HUNT;
            slot_q      <= 2'd0;
            shadow_q[0] <= '0;
            shadow_q[1] <= '0;
            shadow_q[2] <= '0;
            u_q         <= '0;
            v_q         <= '0;
            w_q         <= '0;
            x_q         <= '0;
            fv_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            u_q      <= u_d;
            v_q      <= v_d;
            w_q      <= w_d;
            x_q      <= x_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
        end
    end

    assign out_u       = u_q;
    assign out_v       = v_q;
    assign out_w       = w_q;
    assign out_x       = x_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign frame_valid = fv_q;
    assign sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4 with a queue-based frame
// model compared every cycle, plus literal checkpoints and a frame scoreboard.
module tb_tdm_demux4;

    localparam int WIDTH = 1;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             frame_sync;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] out_u, out_v, out_w, out_x;
    logic [1:0]       slot;
    logic             locked;
    logic             frame_valid;
    logic             sync_err;

    int checks   = 0;
    int failures = 0;
    int fv_count = 0;

    // Model state: samples of the frame being collected, plus lock flag.
    logic [WIDTH-1:0]   frame_q [$];
    logic [4*WIDTH-1:0] exp_q [$];
    bit                 m_locked    = 1'b0;
    bit                 model_ready = 1'b0;
    logic [WIDTH-1:0]   exp_u, exp_v, exp_w, exp_x;
    logic               exp_fv, exp_err;

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .frame_sync  (frame_sync),
        .data_in     (data_in),
        .out_u       (out_u),
        .out_v       (out_v),
        .out_w       (out_w),
        .out_x       (out_x),
        .slot        (slot),
        .locked      (locked),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    // Clock and initial reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is whatever has been collected since the
    // last marker; four samples complete it, a marker restarts it.
    task automatic model_step();
        if (reset) begin
            m_locked = 1'b0;
            frame_q.delete();
            exp_u = '0; exp_v = '0; exp_w = '0; exp_x = '0;
            exp_fv = 1'b0; exp_err = 1'b0;
            model_ready = 1'b1;
        end else begin
            exp_fv  = 1'b0;
            exp_err = 1'b0;
            if (enable) begin
                if (!m_locked) begin
                    if (frame_sync) begin
                        frame_q.delete();
                        frame_q.push_back(data_in);
                        m_locked = 1'b1;
                    end
                end else if (frame_sync) begin
                    if (frame_q.size() != 0) exp_err = 1'b1;
                    frame_q.delete();
                    frame_q.push_back(data_in);
                end else if (frame_q.size() == 0) begin
                    exp_err  = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    frame_q.push_back(data_in);
                    if (frame_q.size() == 4) begin
                        exp_u = frame_q[0];
                        exp_v = frame_q[1];
                        exp_w = frame_q[2];
                        exp_x = frame_q[3];
                        exp_fv = 1'b1;
                        frame_q.delete();
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Compare process: DUT against model on every falling edge, plus scoreboard.
    initial begin
        logic [4*WIDTH-1:0] got, want;
        forever begin
            @(negedge clock);
            if (model_ready) begin
                check("out_u", 32'(out_u), 32'(exp_u));
                check("out_v", 32'(out_v), 32'(exp_v));
                check("out_w", 32'(out_w), 32'(exp_w));
                check("out_x", 32'(out_x), 32'(exp_x));
                check("slot", 32'(slot), 32'(frame_q.size()));
                check("locked", 32'(locked), 32'(m_locked));
                check("frame_valid", 32'(frame_valid), 32'(exp_fv));
                check("sync_err", 32'(sync_err), 32'(exp_err));
                check("fv_err_exclusive", 32'(frame_valid & sync_err), 32'd0);
                if (frame_valid === 1'b1) begin
                    fv_count++;
                    got = {out_u, out_v, out_w, out_x};
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        check("frame_scoreboard", 32'(got), 32'(want));
                    end
                end
            end
        end
    end

    // Driver: apply one cycle of inputs at the falling edge, return just after the rising edge.
    task automatic drive(input logic rst, input logic en, input logic fs, input logic [WIDTH-1:0] d);
        @(negedge clock);
        reset      = rst;
        enable     = en;
        frame_sync = fs;
        data_in    = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int fv_before;
        reset      = 1'b1;
        enable     = 1'b1;
        frame_sync = 1'b1;
        data_in    = 1'b1;
        // Expected frames in order of completion: u,v,w,x packed MSB first.
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b1011);
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b1111);

        // Reset held two cycles with active-looking inputs.
        @(posedge clock); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_outs", 32'({out_u, out_v, out_w, out_x}), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);

        // Continuous frame 1,0,1,1.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("lock_first_beat", 32'(locked), 32'd1);
        check("slot_after_first", 32'(slot), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("frame1_outs", 32'({out_u, out_v, out_w, out_x}), 32'h0000_000B);
        check("frame1_fv", 32'(frame_valid), 32'd1);
        check("frame1_slot", 32'(slot), 32'd0);
        check("model_pin_frame1", 32'({exp_u, exp_v, exp_w, exp_x}), 32'h0000_000B);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("frame1_fv_drop", 32'(frame_valid), 32'd0);

        // Same frame with idle cycles between beats.
        fv_before = fv_count;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_slot_hold", 32'(slot), 32'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("gapped_outs", 32'({out_u, out_v, out_w, out_x}), 32'h0000_000B);
        check("gapped_single_fv", 32'(fv_count - fv_before), 32'd1);

        // Frame 0,1,0,0 with an early marker on slot 2.
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        check("early_err", 32'(sync_err), 32'd1);
        check("early_outs_hold", 32'({out_u, out_v, out_w, out_x}), 32'h0000_000B);
        check("early_slot", 32'(slot), 32'd1);
        check("early_locked", 32'(locked), 32'd1);
        check("model_pin_early", 32'(exp_err), 32'd1);
        // Finish the restarted frame: 0 (marker beat), 1, 0, 1.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("early_err_drop", 32'(sync_err), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("restart_outs", 32'({out_u, out_v, out_w, out_x}), 32'h0000_0005);

        // Missing marker at slot 0 drops lock; later plain beats are ignored.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("miss_err", 32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        check("miss_slot", 32'(slot), 32'd0);
        fv_before = fv_count;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
            check("hunt_no_err", 32'(sync_err), 32'd0);
        end
        check("hunt_no_fv", 32'(fv_count - fv_before), 32'd0);
        check("hunt_locked", 32'(locked), 32'd0);

        // Reset after two beats discards the partial frame and clears outputs.
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("midrst_outs", 32'({out_u, out_v, out_w, out_x}), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_slot", 32'(slot), 32'd0);
        fv_before = fv_count;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        check("final_outs", 32'({out_u, out_v, out_w, out_x}), 32'h0000_000F);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("final_single_fv", 32'(fv_count - fv_before), 32'd1);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
